// File: rtl/lsu_unit_pkg.sv
// lsu_unit_pkg: shared types for the load/store unit.
//   word_t, except_t, mem_req_t (EXU->LSU), bus_query_req_t / bus_query_resp_t (LSU<->bus),
//   access size encodings MEM_B/MEM_H/MEM_W and exception codes.
package lsu_unit_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [3:0] except_t;
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam except_t EXC_NONE           = 4'd0;
    localparam except_t EXC_LOAD_MISALIGN  = 4'd4;
    localparam except_t EXC_LOAD_FAULT     = 4'd5;
    localparam except_t EXC_STORE_MISALIGN = 4'd6;
    localparam except_t EXC_STORE_FAULT    = 4'd7;
    typedef struct packed {
        logic       load;
        logic       store;
        logic [1:0] size;
        logic       sign_ext;
        word_t      addr;
        word_t      wdata;
    } mem_req_t;
    typedef struct packed {
        logic       valid;
        logic       we;
        word_t      addr;
        word_t      wdata;
        logic [3:0] be;
    } bus_query_req_t;
    typedef struct packed {
        logic  ready;
        logic  valid;
        word_t rdata;
    } bus_query_resp_t;
endpackage

// File: rtl/lsu_unit_align.sv
// lsu_unit_align: combinational lane logic shared by the request and response paths.
//   in : size, off (byte offset), sign_ext, wdata, rdata
//   out: be (byte enables), wdata_rep (store data replicated over lanes), load_val (extracted load)
module lsu_unit_align
    import lsu_unit_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] off,
    input  logic       sign_ext,
    input  word_t      wdata,
    input  word_t      rdata,
    output logic [3:0] be,
    output word_t      wdata_rep,
    output word_t      load_val
);
    word_t sh;
    always_comb begin
        sh        = rdata >> {off, 3'b000};
        be        = (size == MEM_B ? 4'b0001 : size == MEM_H ? 4'b0011 : 4'b1111) << off;
        wdata_rep = size == MEM_B ? {4{wdata[7:0]}} : size == MEM_H ? {2{wdata[15:0]}} : wdata;
        load_val  = size == MEM_B ? {{24{sign_ext & sh[7]}}, sh[7:0]} :
                    size == MEM_H ? {{16{sign_ext & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: memory-stage load/store unit issuing one bus_query transaction per legal access.
//   in : clk, rst (async, active-low), in_valid, mem_req, flush, bus_resp
//   out: lsu_busy (pipeline stall), load_data, done (completion pulse), lsu_exception, bus_req
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  mem_req_t        mem_req,
    input  logic            flush,
    output logic            lsu_busy,
    output word_t           load_data,
    output logic            done,
    output except_t         lsu_exception,
    output bus_query_req_t  bus_req,
    input  bus_query_resp_t bus_resp
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} lsu_state_t;
    lsu_state_t  state, state_nx;
    logic [15:0] cnt;
    mem_req_t    req_q, cur;
    logic        live, misaligned, start, timeout, bus_valid;
    logic [3:0]  be;
    word_t       wdata_rep, load_val;
    // Live request drives the bus while idle; the latched copy is used once the access is in flight.
    assign cur        = state == IDLE ? mem_req : req_q;
    // Gating with rst keeps every output at zero for the whole reset window.
    assign live       = rst & in_valid & ~flush & (mem_req.load | mem_req.store);
    assign misaligned = (mem_req.size == MEM_H & mem_req.addr[0]) |
                        (mem_req.size == MEM_W & mem_req.addr[1:0] != 2'b00);
    assign start      = live & ~misaligned & state == IDLE;
    assign timeout    = TIMEOUT_CYCLES != 0 && state == WAIT && cnt >= 16'(TIMEOUT_CYCLES - 1);
    lsu_unit_align u_align (
        .size      (cur.size),
        .off       (cur.addr[1:0]),
        .sign_ext  (cur.sign_ext),
        .wdata     (cur.wdata),
        .rdata     (bus_resp.rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .load_val  (load_val)
    );
    always_comb begin
        state_nx      = state;
        lsu_busy      = 1'b0;
        done          = 1'b0;
        lsu_exception = EXC_NONE;
        bus_valid     = 1'b0;
        case (state)
            IDLE: begin
                if (live & misaligned)
                    lsu_exception = mem_req.load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
                if (start) begin
                    bus_valid = 1'b1;
                    lsu_busy  = 1'b1;
                    state_nx  = bus_resp.ready ? WAIT : REQ;
                end
            end
            REQ: begin
                lsu_busy  = 1'b1;
                bus_valid = ~flush;
                state_nx  = flush ? IDLE : bus_resp.ready ? WAIT : REQ;
            end
            WAIT: begin
                if (bus_resp.valid) begin
                    done     = ~flush;
                    state_nx = IDLE;
                end else if (timeout) begin
                    lsu_exception = cur.load ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
                    state_nx      = IDLE;
                end else begin
                    lsu_busy = 1'b1;
                    state_nx = flush ? DRAIN : WAIT;
                end
            end
            default: begin
                lsu_busy = 1'b1;
                state_nx = bus_resp.valid ? IDLE : DRAIN;
            end
        endcase
    end
    always_comb begin
        bus_req = '0;
        if (bus_valid) begin
            bus_req.valid = 1'b1;
            bus_req.we    = cur.store;
            bus_req.addr  = {cur.addr[ADDR_W-1:2], 2'b00};
            bus_req.wdata = wdata_rep;
            bus_req.be    = be;
        end
    end
    assign load_data = done & cur.load ? load_val : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_nx;
            // Saturating WAIT-cycle counter, cleared on any exit from WAIT.
            cnt   <= state == WAIT && state_nx == WAIT ? cnt + {15'b0, cnt != 16'hFFFF} : '0;
            if (start)
                req_q <= mem_req;
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed self-checking bench for lsu_unit with a transaction-level expectation model.
module tb_lsu_unit;
    import lsu_unit_pkg::*;
    localparam int TO = 4;
    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    mem_req_t        mem_req;
    logic            flush;
    logic            lsu_busy;
    word_t           load_data;
    logic            done;
    except_t         lsu_exception;
    bus_query_req_t  bus_req;
    bus_query_resp_t bus_resp;
    int n_chk = 0;
    int n_fail = 0;
    logic           chk_en = 1'b0;
    logic           exp_busy, exp_done;
    except_t        exp_exc;
    bus_query_req_t exp_bus;
    word_t          exp_ld;
    word_t          last_ld, last_wd;
    logic [3:0]     last_be;
    int             n_done;

    lsu_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .mem_req       (mem_req),
        .flush         (flush),
        .lsu_busy      (lsu_busy),
        .load_data     (load_data),
        .done          (done),
        .lsu_exception (lsu_exception),
        .bus_req       (bus_req),
        .bus_resp      (bus_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int base;
        base = sz == 2'd0 ? 1 : sz == 2'd1 ? 3 : 15;
        return 4'(base * (2 ** int'(a % 4)));
    endfunction

    function automatic word_t m_rep(input logic [1:0] sz, input word_t wd);
        return sz == 2'd0 ? (wd & 32'hFF) * 32'h01010101 :
               sz == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    endfunction

    function automatic word_t m_load(input logic [1:0] sz, input logic sx, input logic [31:0] a, input word_t rd);
        int     bits;
        longint v, span;
        bits = sz == 2'd0 ? 8 : sz == 2'd1 ? 16 : 32;
        span = longint'(1) << bits;
        v    = (longint'(rd) / (longint'(1) << (8 * int'(a % 4)))) % span;
        if (sx && bits < 32 && v >= span / 2)
            v = v - span;
        return v[31:0];
    endfunction

    function automatic bus_query_req_t m_bus(input logic st, input logic [1:0] sz, input logic [31:0] a, input word_t wd);
        bus_query_req_t r;
        r.valid = 1'b1;
        r.we    = st;
        r.addr  = a - (a % 4);
        r.wdata = m_rep(sz, wd);
        r.be    = m_be(sz, a);
        return r;
    endfunction

    task automatic set_idle();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_exc  = EXC_NONE;
        exp_bus  = '0;
        exp_ld   = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", lsu_busy, exp_busy);
            chk("done", done, exp_done);
            chk("exception", lsu_exception, exp_exc);
            chk("bus_req", bus_req, exp_bus);
            if (exp_done)
                chk("load_data", load_data, exp_ld);
        end
        if (done) begin
            last_ld = load_data;
            n_done++;
        end
        if (bus_req.valid) begin
            last_wd = bus_req.wdata;
            last_be = bus_req.be;
        end
    end

    // rl: cycles before ready; vl: WAIT-relative cycle of the response (-1 none);
    // fl: WAIT-relative cycle of flush (-1 none).
    task automatic access(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input word_t wd, input word_t rd,
                          input int rl, input int vl, input int fl);
        logic drain, fin;
        mem_req  = '{load: ld, store: st, size: sz, sign_ext: sx, addr: a, wdata: wd};
        in_valid = 1'b1;
        flush    = 1'b0;
        bus_resp = '{ready: rl == 0, valid: 1'b0, rdata: rd};
        set_idle();
        if (m_mis(sz, a)) begin
            exp_exc = ld ? 4'd4 : 4'd6;
            @(posedge clk); #1;
            in_valid = 1'b0;
            set_idle();
            return;
        end
        exp_busy = 1'b1;
        exp_bus  = m_bus(st, sz, a, wd);
        @(posedge clk); #1;
        for (int i = 1; i <= rl; i++) begin
            bus_resp.ready = i == rl;
            @(posedge clk); #1;
        end
        bus_resp.ready = 1'b0;
        exp_bus = '0;
        drain = 1'b0;
        fin   = 1'b0;
        for (int w = 0; w < 40 && !fin; w++) begin
            bus_resp.valid = w == vl;
            flush          = w == fl;
            exp_busy       = 1'b1;
            if (drain) begin
                fin = w == vl;
            end else if (w == vl) begin
                exp_done = !flush;
                exp_busy = 1'b0;
                exp_ld   = ld ? m_load(sz, sx, a, rd) : '0;
                fin      = 1'b1;
            end else if (w == TO - 1) begin
                exp_exc  = ld ? 4'd5 : 4'd7;
                exp_busy = 1'b0;
                fin      = 1'b1;
            end else if (flush) begin
                drain = 1'b1;
            end
            @(posedge clk); #1;
            flush          = 1'b0;
            bus_resp.valid = 1'b0;
            exp_done       = 1'b0;
            exp_exc        = EXC_NONE;
        end
        if (!fin)
            chk("access_bound", 1'b0, 1'b1);
        in_valid = 1'b0;
        set_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        mem_req  = '0;
        bus_resp = '0;
        n_done   = 0;
        set_idle();
        #1 chk_en = 1'b1;
        // Model pins against hand-computed values.
        chk("pin_lb",  m_load(MEM_B, 1'b1, 32'h1003, 32'h80FF_FF00), 32'hFFFF_FF80);
        chk("pin_lbu", m_load(MEM_B, 1'b0, 32'h5001, 32'h0000_A500), 32'h0000_00A5);
        chk("pin_be",  m_be(MEM_H, 32'h2002), 4'b1100);
        chk("pin_rep", m_rep(MEM_H, 32'h0000_BEEF), 32'hBEEF_BEEF);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        access(1, 0, MEM_B, 1, 32'h1003, 32'h0, 32'h80FF_FF00, 1, 1, -1);
        chk("lb_data", last_ld, 32'hFFFF_FF80);
        chk("lb_be", last_be, 4'b1000);
        access(0, 1, MEM_H, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0, -1);
        chk("sh_wdata", last_wd, 32'hBEEF_BEEF);
        chk("sh_be", last_be, 4'b1100);
        access(1, 0, MEM_W, 0, 32'h3001, 32'h0, 32'h0, 0, 0, -1);
        access(0, 1, MEM_W, 0, 32'h3002, 32'h1234, 32'h0, 0, 0, -1);
        n_done = 0;
        access(1, 0, MEM_H, 0, 32'h4002, 32'h0, 32'hABCD_0000, 0, 6, 1);
        chk("drain_no_done", n_done, 0);
        access(1, 0, MEM_W, 0, 32'h4000, 32'h0, 32'h1234_5678, 0, 0, -1);
        chk("lw_after_drain", last_ld, 32'h1234_5678);
        access(0, 1, MEM_W, 0, 32'h6000, 32'hCAFE_F00D, 32'h0, 0, -1, -1);
        access(1, 0, MEM_H, 1, 32'h7002, 32'h0, 32'h8001_0000, 2, 2, -1);
        chk("lh_data", last_ld, 32'hFFFF_8001);
        n_done = 0;
        access(1, 0, MEM_W, 0, 32'h9000, 32'h0, 32'h5555_AAAA, 0, 1, 1);
        chk("flush_resp_no_done", n_done, 0);
        access(1, 0, MEM_B, 0, 32'hA002, 32'h0, 32'h0077_0000, 0, 3, -1);
        chk("lbu_resp_vs_timeout", last_ld, 32'h0000_0077);

        // Flush beats a start in IDLE.
        mem_req  = '{load: 1'b1, store: 1'b0, size: MEM_W, sign_ext: 1'b0, addr: 32'hB000, wdata: 32'h0};
        in_valid = 1'b1;
        flush    = 1'b1;
        set_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk); #1;

        // Reset while a request is pending in REQ.
        mem_req  = '{load: 1'b0, store: 1'b1, size: MEM_W, sign_ext: 1'b0, addr: 32'h8004, wdata: 32'h11};
        in_valid = 1'b1;
        bus_resp = '0;
        exp_busy = 1'b1;
        exp_bus  = m_bus(1'b1, MEM_W, 32'h8004, 32'h11);
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        set_idle();
        #1;
        chk("rst_bus_req", bus_req, '0);
        chk("rst_busy", lsu_busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_exc", lsu_exception, EXC_NONE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        access(1, 0, MEM_B, 0, 32'h5001, 32'h0, 32'h0000_A500, 0, 1, -1);
        chk("lbu_after_rst", last_ld, 32'h0000_00A5);

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
